psum_requant_drain: RTL

- Drains finished convolution results from the partial-sum buffer after the PE controller signals done.
- For each valid output pixel it adds a per-channel bias, rounds and shifts, optionally applies ReLU, and saturates to int8.
- Packs 16 int8 lanes per pixel and streams them to output/activation memory over a valid/ready interface.
- Sits directly downstream of psum_buffer, and feeds the next layer's input memory.

---
 rtl/psum_requant_drain_pkg.sv | 12 +
 rtl/psum_requant_drain_requant_lane.sv | 28 ++
 rtl/psum_requant_drain.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/psum_requant_drain_pkg.sv
// psum_requant_drain_pkg: shared widths, int8 limits and FSM state encodings
package psum_requant_drain_pkg;
  localparam int ACC_WIDTH  = 32;
  localparam int DATA_WIDTH = 8;
  localparam int INT8_MAX   = 127;
  localparam int INT8_MIN   = -128;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ISSUE  = 2'd1;
  localparam state_t S_DRAIN  = 2'd2;
  localparam state_t S_FINISH = 2'd3;
endpackage

// File: rtl/psum_requant_drain_requant_lane.sv
// requant_lane: per-lane bias/round/shift (first half) and relu/saturate/mask (second half)
module requant_lane
  import psum_requant_drain_pkg::*;
(
  input  logic signed [ACC_WIDTH-1:0]  i_acc,
  input  logic signed [ACC_WIDTH-1:0]  i_bias,
  input  logic        [4:0]            i_shift,
  output logic signed [ACC_WIDTH+1:0]  o_shifted,
  input  logic signed [ACC_WIDTH+1:0]  i_val,
  input  logic                         i_relu,
  input  logic                         i_keep,
  output logic        [DATA_WIDTH-1:0] o_q
);
  localparam int SW = ACC_WIDTH + 2;
  localparam logic signed [SW-1:0] W_MAX = SW'(INT8_MAX);
  localparam logic signed [SW-1:0] W_MIN = SW'(INT8_MIN);
  logic signed [SW-1:0] w_rnd;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_pos;
  // two guard bits: full-scale acc+bias plus the rounding constant can exceed 33 bits
  assign w_rnd = (i_shift == 5'd0) ? '0 : SW'(1) << (i_shift - 5'd1);
  assign w_sum = SW'(i_acc) + SW'(i_bias) + w_rnd;
  assign o_shifted = w_sum >>> i_shift;
  assign w_pos = (i_relu && i_val[SW-1]) ? '0 : i_val;
  assign o_q = !i_keep ? '0 :
               (w_pos > W_MAX) ? DATA_WIDTH'(INT8_MAX) :
               (w_pos < W_MIN) ? DATA_WIDTH'(INT8_MIN) : w_pos[DATA_WIDTH-1:0];
endmodule

// File: rtl/psum_requant_drain.sv
// psum_requant_drain: drains psum buffer, requantizes to int8 and streams pixels out
module psum_requant_drain
  import psum_requant_drain_pkg::*;
#(
  parameter int ARRAY_DIM  = 16,
  parameter int BUF_AW     = 10,
  parameter int OUT_AW     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  output logic                            o_busy,
  output logic                            o_done,
  input  logic [7:0]                      i_out_h,
  input  logic [7:0]                      i_out_w,
  input  logic [7:0]                      i_row_stride,
  input  logic [4:0]                      i_cout,
  input  logic [4:0]                      i_shift,
  input  logic                            i_relu_en,
  input  logic [OUT_AW-1:0]               i_out_base,
  input  logic [ARRAY_DIM*ACC_WIDTH-1:0]  i_bias_vec,
  output logic                            o_buf_rd_en,
  output logic [BUF_AW-1:0]               o_buf_rd_addr,
  input  logic [ARRAY_DIM*ACC_WIDTH-1:0]  i_buf_rd_data,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic [OUT_AW-1:0]               o_out_addr,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] o_out_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = ARRAY_DIM * DATA_WIDTH;
  localparam int SW = ACC_WIDTH + 2;
  state_t                       r_state;
  logic [7:0]                   r_h, r_w, r_stride, r_oy, r_ox;
  logic [4:0]                   r_cout, r_shift;
  logic                         r_relu;
  logic [OUT_AW-1:0]            r_base;
  logic                         r_rd_v, r_s1_v, r_s2_v;
  logic [OUT_AW-1:0]            r_rd_oaddr, r_s1_oaddr, r_s2_oaddr;
  logic [ARRAY_DIM*ACC_WIDTH-1:0] r_s1_data;
  logic [ARRAY_DIM*SW-1:0]      r_s2_data;
  logic [OUT_AW+DW-1:0]         r_fifo [FIFO_DEPTH];
  logic [PW-1:0]                r_head, r_tail;
  logic [PW:0]                  r_count;
  logic [ARRAY_DIM*SW-1:0]      w_s2_next;
  logic [DW-1:0]                w_q;
  logic [OUT_AW-1:0]            w_out_addr;
  logic [PW+1:0]                w_occ;
  logic                         w_issue, w_pop, w_push, w_empty;
  assign w_pop   = o_out_valid && i_out_ready;
  assign w_push  = r_s2_v;
  assign w_empty = (r_count == '0) && !r_rd_v && !r_s1_v && !r_s2_v;
  // an entry popped this cycle frees its slot immediately, so 1 pixel/cycle is sustainable
  assign w_occ = (PW+2)'(r_count) - (PW+2)'(w_pop) + (PW+2)'(r_rd_v)
               + (PW+2)'(r_s1_v) + (PW+2)'(r_s2_v);
  assign w_issue = (r_state == S_ISSUE) && (w_occ < (PW+2)'(FIFO_DEPTH));
  assign o_buf_rd_en   = w_issue;
  assign o_buf_rd_addr = BUF_AW'(16'(r_oy) * 16'(r_stride) + 16'(r_ox));
  assign w_out_addr    = r_base + OUT_AW'(r_oy) * OUT_AW'(r_w) + OUT_AW'(r_ox);
  assign o_busy        = r_state != S_IDLE;
  assign o_done        = r_state == S_FINISH;
  assign o_out_valid   = r_count != '0;
  assign {o_out_addr, o_out_data} = r_fifo[r_head];
  for (genvar c = 0; c < ARRAY_DIM; c++) begin : g_lane
    requant_lane u_lane (
      .i_acc     (r_s1_data[c*ACC_WIDTH +: ACC_WIDTH]),
      .i_bias    (i_bias_vec[c*ACC_WIDTH +: ACC_WIDTH]),
      .i_shift   (r_shift),
      .o_shifted (w_s2_next[c*SW +: SW]),
      .i_val     (r_s2_data[c*SW +: SW]),
      .i_relu    (r_relu),
      .i_keep    (5'(c) < r_cout),
      .o_q       (w_q[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end
  // control FSM: config latch and row-major pixel walk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_h      <= '0;
      r_w      <= '0;
      r_stride <= '0;
      r_cout   <= '0;
      r_shift  <= '0;
      r_relu   <= 1'b0;
      r_base   <= '0;
      r_oy     <= '0;
      r_ox     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_h      <= i_out_h;
          r_w      <= i_out_w;
          r_stride <= i_row_stride;
          r_cout   <= i_cout;
          r_shift  <= i_shift;
          r_relu   <= i_relu_en;
          r_base   <= i_out_base;
          r_oy     <= '0;
          r_ox     <= '0;
          r_state  <= (i_out_h == '0 || i_out_w == '0) ? S_FINISH : S_ISSUE;
        end
        S_ISSUE: if (w_issue) begin
          if (r_ox == r_w - 8'd1) begin
            r_ox <= '0;
            if (r_oy == r_h - 8'd1) r_state <= S_DRAIN;
            else r_oy <= r_oy + 8'd1;
          end else begin
            r_ox <= r_ox + 8'd1;
          end
        end
        S_DRAIN: if (w_empty) r_state <= S_FINISH;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // three-stage requant pipeline with the output address riding alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_v     <= 1'b0;
      r_s1_v     <= 1'b0;
      r_s2_v     <= 1'b0;
      r_rd_oaddr <= '0;
      r_s1_oaddr <= '0;
      r_s2_oaddr <= '0;
      r_s1_data  <= '0;
      r_s2_data  <= '0;
    end else begin
      r_rd_v     <= w_issue;
      r_rd_oaddr <= w_out_addr;
      r_s1_v     <= r_rd_v;
      r_s1_oaddr <= r_rd_oaddr;
      r_s1_data  <= i_buf_rd_data;
      r_s2_v     <= r_s1_v;
      r_s2_oaddr <= r_s1_oaddr;
      r_s2_data  <= w_s2_next;
    end
  end
  // output FIFO; credits guarantee it never overflows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_tail] <= {r_s2_oaddr, w_q};
        r_tail         <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
endmodule
